// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file's two write ports among NUM_REQ writeback sources.
// Define RF_ARB_PERF_EN to add the dual-grant and address-conflict performance counters.
module regfile_wr_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
    output logic [ADDR_WIDTH-1:0]          waddr_a_o,
    output logic [DATA_WIDTH-1:0]          wdata_a_o,
    output logic                           we_a_o,
    output logic [ADDR_WIDTH-1:0]          waddr_b_o,
    output logic [DATA_WIDTH-1:0]          wdata_b_o,
    output logic                           we_b_o
`ifdef RF_ARB_PERF_EN
    ,
    input  logic                           perf_clr_i,
    output logic [15:0]                    perf_dual_o,
    output logic [15:0]                    perf_conflict_o
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t                  rr_ptr;
    ptr_t                  rr_ptr_next;
    logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data [NUM_REQ];
    logic [NUM_REQ-1:0]    is_x0;
    logic [NUM_REQ-1:0]    cand;
    logic [NUM_REQ-1:0]    grant;
    logic                  g1_found;
    logic                  g2_found;
    ptr_t                  g1_idx;
    ptr_t                  g2_idx;
    logic                  clash;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr[i]  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            data[i]  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            is_x0[i] = req_valid_i[i] && (addr[i] == '0);
            cand[i]  = req_valid_i[i] && (addr[i] != '0);
        end
    end

    // Circular search from rr_ptr: first candidate takes port A, the next one with a
    // different address takes port B; any same-address candidate is held off.
    always_comb begin : grant_search
        int idx;
        // NOTE: every output of this block gets a default first so no latch is inferred;
        // blocking assignments are used here because later iterations read earlier results.
        g1_found = 1'b0;
        g2_found = 1'b0;
        g1_idx   = '0;
        g2_idx   = '0;
        clash    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (cand[idx]) begin
                if (!g1_found) begin
                    g1_found = 1'b1;
                    g1_idx   = ptr_t'(idx);
                end else if (addr[idx] == addr[g1_idx]) begin
                    clash = 1'b1;
                end else if (!g2_found) begin
                    g2_found = 1'b1;
                    g2_idx   = ptr_t'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = (g1_found && (g1_idx == ptr_t'(i))) ||
                       (g2_found && (g2_idx == ptr_t'(i)));
        end
        req_ready_o = rst ? '0 : (is_x0 | grant);

        rr_ptr_next = rr_ptr;
        if (g2_found)      rr_ptr_next = ptr_inc(g2_idx);
        else if (g1_found) rr_ptr_next = ptr_inc(g1_idx);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
            we_b_o    <= 1'b0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            we_a_o <= g1_found;
            we_b_o <= g2_found;
            if (g1_found) begin
                waddr_a_o <= addr[g1_idx];
                wdata_a_o <= data[g1_idx];
            end
            if (g2_found) begin
                waddr_b_o <= addr[g2_idx];
                wdata_b_o <= data[g2_idx];
            end
        end
    end

`ifdef RF_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dual_o     <= '0;
            perf_conflict_o <= '0;
        end else if (perf_clr_i) begin
            perf_dual_o     <= '0;
            perf_conflict_o <= '0;
        end else begin
            if (g1_found && g2_found && (perf_dual_o != 16'hFFFF))
                perf_dual_o <= perf_dual_o + 16'd1;
            if (clash && (perf_conflict_o != 16'hFFFF))
                perf_conflict_o <= perf_conflict_o + 16'd1;
        end
    end
`endif

endmodule
